// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Moore control FSM sequencing the multicycle RV32I-subset datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       Illegal
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECR    = 4'd6;
    localparam logic [3:0] c_EXECI    = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BRANCH   = 4'd9;
    localparam logic [3:0] c_JAL      = 4'd10;
    localparam logic [3:0] c_JALR1    = 4'd11;
    localparam logic [3:0] c_JALR2    = 4'd12;
    localparam logic [3:0] c_LUI      = 4'd13;

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_LUI  = 7'b0110111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_XOR = 3'b100;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    logic [3:0] state_q, state_d;
    logic       w_pcwrite, w_memwrite, w_irwrite, w_regwrite, w_illegal;
    logic [2:0] w_alu_func;
    logic       w_take;

    always_ff @(posedge clk) begin
        if (rst) state_q <= c_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (Op)
            c_OP_SW:  ImmSrc = 3'b001;
            c_OP_BR:  ImmSrc = 3'b010;
            c_OP_JAL: ImmSrc = 3'b011;
            c_OP_LUI: ImmSrc = 3'b100;
            default:  ImmSrc = 3'b000;
        endcase
    end

    // Subtract only for R-type; the same Funct7 bit is immediate data in I-type.
    always_comb begin
        w_alu_func = c_ALU_ADD;
        case (Funct3)
            3'b000:  w_alu_func = (state_q == c_EXECR && Funct7b5) ? c_ALU_SUB : c_ALU_ADD;
            3'b100:  w_alu_func = c_ALU_XOR;
            3'b110:  w_alu_func = c_ALU_OR;
            3'b111:  w_alu_func = c_ALU_AND;
            3'b010:  w_alu_func = c_ALU_SLT;
            default: w_alu_func = c_ALU_ADD;
        endcase
    end

    assign w_take = ((Funct3 == 3'b000) &  Zero) |
                    ((Funct3 == 3'b001) & ~Zero) |
                    ((Funct3 == 3'b100) &  Lt);

    always_comb begin
        state_d    = state_q;
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = c_ALU_ADD;
        case (state_q)
            c_FETCH: begin
                ResultSrc = 2'b10;
                ALUSrcB   = 2'b10;
                w_irwrite = MemReady;
                w_pcwrite = MemReady;
                if (MemReady) state_d = c_DECODE;
            end
            c_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Op)
                    c_OP_LW, c_OP_SW: state_d = c_MEMADR;
                    c_OP_R:           state_d = c_EXECR;
                    c_OP_I:           state_d = c_EXECI;
                    c_OP_BR:          state_d = c_BRANCH;
                    c_OP_JAL:         state_d = c_JAL;
                    c_OP_JALR:        state_d = c_JALR1;
                    c_OP_LUI:         state_d = c_LUI;
                    default: begin
                        w_illegal = 1'b1;
                        state_d   = c_FETCH;
                    end
                endcase
            end
            c_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (Op == c_OP_SW) ? c_MEMWRITE : c_MEMREAD;
            end
            c_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = c_MEMWB;
            end
            c_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                state_d    = c_FETCH;
            end
            c_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                if (MemReady) state_d = c_FETCH;
            end
            c_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_alu_func;
                state_d    = c_ALUWB;
            end
            c_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_func;
                state_d    = c_ALUWB;
            end
            c_ALUWB: begin
                w_regwrite = 1'b1;
                state_d    = c_FETCH;
            end
            c_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = c_ALU_SUB;
                w_pcwrite  = w_take;
                state_d    = c_FETCH;
            end
            c_JAL, c_JALR2: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcwrite = 1'b1;
                state_d   = c_ALUWB;
            end
            c_JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = c_JALR2;
            end
            c_LUI: begin
                ResultSrc  = 2'b11;
                w_regwrite = 1'b1;
                state_d    = c_FETCH;
            end
            default: state_d = c_FETCH;
        endcase
    end

    // Enables are masked during reset so a half-finished instruction cannot commit.
    assign PCWrite  = w_pcwrite  & ~rst;
    assign MemWrite = w_memwrite & ~rst;
    assign IRWrite  = w_irwrite  & ~rst;
    assign RegWrite = w_regwrite & ~rst;
    assign Illegal  = w_illegal  & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Scoreboard bench for multicycle_controller using directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] Funct3;
    logic       Funct7b5, Zero, Lt, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
        .Zero(Zero), .Lt(Lt), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [19:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [19:0] w_act;

    assign w_act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal};

    // Field order: pc adr mw ir rw rs a b alu imm ill
    function automatic logic [19:0] v(input logic pc, input logic adr, input logic mw,
                                      input logic ir, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] alu, input logic [2:0] imm,
                                      input logic ill);
        return {pc, adr, mw, ir, rw, rs, a, b, alu, imm, ill};
    endfunction

    function automatic logic [19:0] e_fetch(input logic mr, input logic [2:0] imm);
        return v(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
    endfunction
    function automatic logic [19:0] e_rstf(input logic [2:0] imm);
        return v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
    endfunction
    function automatic logic [19:0] e_decode(input logic [2:0] imm);
        return v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0);
    endfunction
    function automatic logic [19:0] e_memadr(input logic [2:0] imm);
        return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0);
    endfunction
    function automatic logic [19:0] e_memread();
        return v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_memwb();
        return v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_memwrite();
        return v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0);
    endfunction
    function automatic logic [19:0] e_execr(input logic [2:0] alu);
        return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_execi(input logic [2:0] alu);
        return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_aluwb(input logic [2:0] imm);
        return v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0);
    endfunction
    function automatic logic [19:0] e_branch(input logic pc);
        return v(pc, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0);
    endfunction
    function automatic logic [19:0] e_jal(input logic [2:0] imm);
        return v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, imm, 0);
    endfunction

    task automatic cyc(input string name, input logic [19:0] e);
        exp_t t;
        t.name = name;
        t.v    = e;
        sb.push_back(t);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            n_tests++;
            if (w_act !== m_e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b (pc adr mw ir rw rs a b alu imm ill)",
                         m_e.name, w_act, m_e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Op = 7'b0000011; Funct3 = 3'b000; Funct7b5 = 1'b0;
        Zero = 1'b0; Lt = 1'b0; MemReady = 1'b1;
        @(posedge clk); #1;
        cyc("reset0", e_rstf(3'b000));
        cyc("reset1", e_rstf(3'b000));
        rst = 1'b0;

        // lw stalled in MEMREAD, then reset arrives mid-wait
        cyc("lwA_fetch", e_fetch(1, 3'b000));
        cyc("lwA_decode", e_decode(3'b000));
        cyc("lwA_memadr", e_memadr(3'b000));
        MemReady = 1'b0;
        cyc("lwA_memread", e_memread());
        rst = 1'b1;
        cyc("rst_in_memread", e_memread());
        cyc("rst_fetch", e_rstf(3'b000));
        rst = 1'b0; MemReady = 1'b1;

        cyc("lw_fetch", e_fetch(1, 3'b000));
        cyc("lw_decode", e_decode(3'b000));
        cyc("lw_memadr", e_memadr(3'b000));
        cyc("lw_memread", e_memread());
        cyc("lw_memwb", e_memwb());

        Op = 7'b0100011;
        cyc("sw_fetch", e_fetch(1, 3'b001));
        cyc("sw_decode", e_decode(3'b001));
        cyc("sw_memadr", e_memadr(3'b001));
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) cyc("sw_wait", e_memwrite());
        MemReady = 1'b1;
        cyc("sw_done", e_memwrite());

        Op = 7'b0110011; Funct3 = 3'b000; Funct7b5 = 1'b1;
        cyc("sub_fetch", e_fetch(1, 3'b000));
        cyc("sub_decode", e_decode(3'b000));
        cyc("sub_exec", e_execr(3'b001));
        cyc("sub_wb", e_aluwb(3'b000));

        Op = 7'b0010011;
        cyc("addi_fetch", e_fetch(1, 3'b000));
        cyc("addi_decode", e_decode(3'b000));
        cyc("addi_exec", e_execi(3'b000));
        cyc("addi_wb", e_aluwb(3'b000));

        Op = 7'b0110011; Funct3 = 3'b111;
        cyc("and_fetch", e_fetch(1, 3'b000));
        cyc("and_decode", e_decode(3'b000));
        cyc("and_exec", e_execr(3'b010));
        cyc("and_wb", e_aluwb(3'b000));

        Op = 7'b0010011; Funct3 = 3'b010;
        cyc("slti_fetch", e_fetch(1, 3'b000));
        cyc("slti_decode", e_decode(3'b000));
        cyc("slti_exec", e_execi(3'b101));
        cyc("slti_wb", e_aluwb(3'b000));

        Op = 7'b1100011; Funct7b5 = 1'b0;
        Funct3 = 3'b000; Zero = 1'b1; Lt = 1'b0;
        cyc("beq_fetch", e_fetch(1, 3'b010));
        cyc("beq_decode", e_decode(3'b010));
        cyc("beq_taken", e_branch(1));
        Funct3 = 3'b001; Zero = 1'b1; Lt = 1'b0;
        cyc("bne_fetch", e_fetch(1, 3'b010));
        cyc("bne_decode", e_decode(3'b010));
        cyc("bne_not_taken", e_branch(0));
        Funct3 = 3'b100; Zero = 1'b0; Lt = 1'b1;
        cyc("blt_fetch", e_fetch(1, 3'b010));
        cyc("blt_decode", e_decode(3'b010));
        cyc("blt_taken", e_branch(1));
        Funct3 = 3'b010; Zero = 1'b1; Lt = 1'b1;
        cyc("br010_fetch", e_fetch(1, 3'b010));
        cyc("br010_decode", e_decode(3'b010));
        cyc("br010_not_taken", e_branch(0));
        Zero = 1'b0; Lt = 1'b0; Funct3 = 3'b000;

        Op = 7'b1101111;
        cyc("jal_fetch", e_fetch(1, 3'b011));
        cyc("jal_decode", e_decode(3'b011));
        cyc("jal_pc", e_jal(3'b011));
        cyc("jal_wb", e_aluwb(3'b011));

        Op = 7'b1100111;
        cyc("jalr_fetch", e_fetch(1, 3'b000));
        cyc("jalr_decode", e_decode(3'b000));
        cyc("jalr1", e_memadr(3'b000));
        cyc("jalr2_pc", e_jal(3'b000));
        cyc("jalr_wb", e_aluwb(3'b000));

        Op = 7'b0110111;
        cyc("lui_fetch", e_fetch(1, 3'b100));
        cyc("lui_decode", e_decode(3'b100));
        cyc("lui_wb", v(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 0));

        Op = 7'b0000000;
        cyc("ill_fetch", e_fetch(1, 3'b000));
        cyc("ill_decode", v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1));
        MemReady = 1'b0;
        cyc("ill_back_fetch_wait", e_fetch(0, 3'b000));
        MemReady = 1'b1;
        cyc("ill_fetch2", e_fetch(1, 3'b000));
        cyc("ill_decode2", v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1));

        @(negedge clk); #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM for the multicycle RV32I-subset datapath. It drives every select line of the shared 2/3/4-input datapath multiplexers, every architectural write enable and the ALU operation, sequencing one instruction over 3–5 states. It waits on a single memory-ready handshake and sits between the instruction register and the datapath.

## Interface
- No parameters; all encodings below are fixed.
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Op  input  7  instruction [6:0], from the instruction register.
- Funct3  input  3  instruction [14:12].
- Funct7b5  input  1  instruction [30].
- Zero  input  1  ALU result == 0.
- Lt  input  1  ALU signed less-than flag from the current subtraction.
- MemReady  input  1  memory has completed the current access this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  address mux: 0 = PC, 1 = Result.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  IR/OldPC register enable.
- RegWrite  output  1  register-file write enable.
- ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- ALUSrcA  output  2  A mux: 00 = PC, 01 = OldPC, 10 = RegA.
- ALUSrcB  output  2  B mux: 00 = RegB, 01 = ImmExt, 10 = constant 4.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
- Illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode.

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - branch 1100011 (beq/bne/blt)
  - jal 1101111
  - jalr 1100111
  - lui 0110111
- Unlisted outputs are 0 in each state. ImmSrc is decoded combinationally from Op in every state; it is 000 for unsupported opcodes.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite equal MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add (ALUOut ← OldPC+imm).
  - Next state by Op: lw/sw → MEMADR; R → EXECR; I-ALU → EXECI; branch → BRANCH; jal → JAL; jalr → JALR1; lui → LUI.
  - Any other opcode: Illegal=1, next state FETCH, no writes.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE:
  - AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite stays asserted while waiting; on MemReady=1 the next state is FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU op from Funct3/Funct7b5, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALU op from Funct3 (Funct7b5 ignored), then ALUWB.
- ALU decode by Funct3:
  - 000: add, or sub when the state is EXECR and Funct7b5=1.
  - 100: xor. 110: or. 111: and. 010: slt.
  - Others: add.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = (Funct3=000 & Zero) | (Funct3=001 & ~Zero) | (Funct3=100 & Lt). Any other Funct3 gives PCWrite=0.
  - Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (rd ← OldPC+4).
- JALR1: ALUSrcA=10, ALUSrcB=01, add (ALUOut ← rs1+imm), then JALR2. Clearing bit 0 of the target is the datapath's job.
- JALR2: identical outputs to JAL, then ALUWB.
- LUI: ResultSrc=11, RegWrite=1, then FETCH.

## Timing
- Cycles per instruction with MemReady high every cycle:
  - lw 5; sw 4; R/I 4; branch 3; jal 4; jalr 5; lui 3; illegal 2.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Reset:
  - While rst=1, the outputs PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced to 0 combinationally.
  - The state becomes FETCH at the first rising edge with rst=1, including when reset arrives mid-instruction or mid-wait.
  - The first cycle after rst falls is FETCH.
- Outputs depend only on state, except: ImmSrc (Op), ALUControl (Funct3/Funct7b5), Illegal (Op), and the MemReady/Zero/Lt gating in FETCH/BRANCH.
- MemReady is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored elsewhere.

## Test plan
- Reset and lw:
  - Stimulus: rst high for 2 cycles during MEMREAD, then Op=0000011 with MemReady=1.
  - Required: all enables 0 during reset; states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 in cycle 5 only, with ResultSrc=01.
- sw with wait:
  - Stimulus: Op=0100011, MemReady=0 for 3 cycles in MEMWRITE.
  - Required: MemWrite=1 for 4 consecutive cycles, AdrSrc=1 throughout, 7 cycles total, RegWrite never set.
- R-type sub versus I-type addi:
  - Stimulus: Funct3=000, Funct7b5=1.
  - Required: ALUControl=001 for Op=0110011 and 000 for Op=0010011 in the execute state; RegWrite in cycle 4.
- Branches:
  - beq (Funct3=000) with Zero=1 → PCWrite=1 in cycle 3.
  - bne (Funct3=001) with Zero=1 → PCWrite=0.
  - blt (Funct3=100) with Lt=1 → PCWrite=1.
  - Funct3=010 → PCWrite=0.
- jal/jalr:
  - Op=1101111 → PCWrite in cycle 3, RegWrite in cycle 4.
  - Op=1100111 → JALR1 shows ALUSrcA=10, ALUSrcB=01; PCWrite in cycle 4, RegWrite in cycle 5.
- lui and illegal:
  - Op=0110111 → RegWrite with ResultSrc=11 and ImmSrc=100 in cycle 3.
  - Op=0000000 → Illegal=1 in DECODE only, back to FETCH in cycle 3, no writes.
